// File: rtl/csr_trap_unit.sv
// rtl/csr_trap_unit.sv - CSR state, trap entry/return and privilege tracking with registered redirect
module csr_trap_unit #(
   parameter int              XLEN        = 64,
   parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            csrin_valid,
   input  logic            csrin_stall,
   input  logic [31:0]     csrin_inst,
   input  logic [XLEN-1:0] csrin_pc,
   input  logic [XLEN-1:0] csrin_rs1_data,
   input  logic            csrin_csr_write,
   input  logic            csrin_is_mret,
   input  logic            csrin_is_sret,
   output logic [XLEN-1:0] csrout_rdata,
   output logic            csrout_redirect,
   output logic [XLEN-1:0] csrout_redirect_pc,
   output logic [1:0]      csrout_priv,
   output logic [XLEN-1:0] csrout_satp
);

   // sstatus exposes SIE, SPIE, SPP, SUM and MXR of mstatus
   localparam logic [XLEN-1:0] SSTATUS_MASK = XLEN'(64'h00000000000C0122);
   localparam logic [31:0]     INST_ECALL   = 32'h00000073;
   localparam logic [31:0]     INST_UNIMP   = 32'hc0001073;
   localparam int MS_SIE  = 1;
   localparam int MS_MIE  = 3;
   localparam int MS_SPIE = 5;
   localparam int MS_MPIE = 7;
   localparam int MS_SPP  = 8;
   localparam int MS_MPP  = 11;

   logic [XLEN-1:0] mstatus_q, mstatus_d, mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d;
   logic [XLEN-1:0] stvec_q, stvec_d, sepc_q, sepc_d, scause_q, scause_d, satp_q, satp_d;
   logic [1:0]      priv_q, priv_d;
   logic            redirect_q, redirect_d;
   logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

   logic [11:0]     csr_addr;
   logic [2:0]      funct3;
   logic [4:0]      uimm;
   logic [XLEN-1:0] csr_old, csr_src, csr_wval;
   logic            csr_wen;
   logic            commit, do_ecall, do_unimp, do_mret, do_sret, do_csr;

   assign csr_addr = csrin_inst[31:20];
   assign funct3   = csrin_inst[14:12];
   assign uimm     = csrin_inst[19:15];

   // The cycle right after a redirect carries a wrong-path instruction and never commits
   assign commit   = csrin_valid & ~csrin_stall & ~redirect_q;
   assign do_ecall = csrin_csr_write & (csrin_inst == INST_ECALL);
   assign do_unimp = csrin_csr_write & (csrin_inst == INST_UNIMP) & ~do_ecall;
   assign do_mret  = csrin_is_mret & ~do_ecall & ~do_unimp;
   assign do_sret  = csrin_is_sret & ~do_ecall & ~do_unimp & ~do_mret;
   assign do_csr   = csrin_csr_write & ~do_ecall & ~do_unimp & ~do_mret & ~do_sret;

   // Combinational read of the addressed CSR (pre-update value)
   always_comb begin
      csr_old = '0;
      case (csr_addr)
         12'h300: csr_old = mstatus_q;
         12'h305: csr_old = mtvec_q;
         12'h341: csr_old = mepc_q;
         12'h342: csr_old = mcause_q;
         12'h100: csr_old = mstatus_q & SSTATUS_MASK;
         12'h105: csr_old = stvec_q;
         12'h141: csr_old = sepc_q;
         12'h142: csr_old = scause_q;
         12'h180: csr_old = satp_q;
         default: csr_old = '0;
      endcase
   end

   // Zicsr write value; set/clear with a zero source field leaves the CSR untouched
   always_comb begin
      csr_src = funct3[2] ? {{(XLEN-5){1'b0}}, uimm} : csrin_rs1_data;
      case (funct3[1:0])
         2'b01:   csr_wval = csr_src;
         2'b10:   csr_wval = csr_old | csr_src;
         2'b11:   csr_wval = csr_old & ~csr_src;
         default: csr_wval = csr_old;
      endcase
      csr_wen = (funct3[1:0] != 2'b00) && !(funct3[1] && (uimm == 5'd0));
   end

   // Next architectural state: trap entry, returns, or a single CSR write
   always_comb begin
      mstatus_d     = mstatus_q;
      mtvec_d       = mtvec_q;
      mepc_d        = mepc_q;
      mcause_d      = mcause_q;
      stvec_d       = stvec_q;
      sepc_d        = sepc_q;
      scause_d      = scause_q;
      satp_d        = satp_q;
      priv_d        = priv_q;
      redirect_d    = 1'b0;
      redirect_pc_d = redirect_pc_q;
      if (commit) begin
         if (do_ecall || do_unimp) begin
            mepc_d   = csrin_pc;
            mcause_d = do_ecall ? {{(XLEN-4){1'b0}}, 4'd8 + {2'b00, priv_q}}
                                : {{(XLEN-2){1'b0}}, 2'b10};
            mstatus_d[MS_MPP +: 2] = priv_q;
            mstatus_d[MS_MPIE]     = mstatus_q[MS_MIE];
            mstatus_d[MS_MIE]      = 1'b0;
            priv_d        = 2'b11;
            redirect_d    = 1'b1;
            redirect_pc_d = mtvec_q;
         end else if (do_mret) begin
            priv_d                 = mstatus_q[MS_MPP +: 2];
            mstatus_d[MS_MIE]      = mstatus_q[MS_MPIE];
            mstatus_d[MS_MPIE]     = 1'b1;
            mstatus_d[MS_MPP +: 2] = 2'b00;
            redirect_d    = 1'b1;
            redirect_pc_d = mepc_q;
         end else if (do_sret) begin
            priv_d             = {1'b0, mstatus_q[MS_SPP]};
            mstatus_d[MS_SIE]  = mstatus_q[MS_SPIE];
            mstatus_d[MS_SPIE] = 1'b1;
            mstatus_d[MS_SPP]  = 1'b0;
            redirect_d    = 1'b1;
            redirect_pc_d = sepc_q;
         end else if (do_csr && csr_wen) begin
            case (csr_addr)
               12'h300: mstatus_d = csr_wval;
               12'h305: mtvec_d   = {csr_wval[XLEN-1:2], 2'b00};
               12'h341: mepc_d    = {csr_wval[XLEN-1:2], 2'b00};
               12'h342: mcause_d  = csr_wval;
               12'h100: mstatus_d = (mstatus_q & ~SSTATUS_MASK) | (csr_wval & SSTATUS_MASK);
               12'h105: stvec_d   = {csr_wval[XLEN-1:2], 2'b00};
               12'h141: sepc_d    = {csr_wval[XLEN-1:2], 2'b00};
               12'h142: scause_d  = csr_wval;
               12'h180: satp_d    = csr_wval;
               default: ;
            endcase
         end
      end
   end

   // State registers; reset also kills any pending redirect immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mstatus_q     <= '0;
         mtvec_q       <= MTVEC_RESET;
         mepc_q        <= '0;
         mcause_q      <= '0;
         stvec_q       <= '0;
         sepc_q        <= '0;
         scause_q      <= '0;
         satp_q        <= '0;
         priv_q        <= 2'b11;
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
      end else begin
         mstatus_q     <= mstatus_d;
         mtvec_q       <= mtvec_d;
         mepc_q        <= mepc_d;
         mcause_q      <= mcause_d;
         stvec_q       <= stvec_d;
         sepc_q        <= sepc_d;
         scause_q      <= scause_d;
         satp_q        <= satp_d;
         priv_q        <= priv_d;
         redirect_q    <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
      end
   end

   assign csrout_rdata       = csr_old;
   assign csrout_redirect    = redirect_q;
   assign csrout_redirect_pc = redirect_pc_q;
   assign csrout_priv        = priv_q;
   assign csrout_satp        = satp_q;

endmodule

// File: tb/tb_csr_trap_unit.sv
// tb/tb_csr_trap_unit.sv - scoreboard bench for csr_trap_unit with a CSR-map reference model
module tb_csr_trap_unit;

   localparam int          XLEN      = 64;
   localparam logic [63:0] MTVEC_RST = 64'h100;
   localparam logic [63:0] SMASK     = 64'hC0122;
   localparam logic [31:0] ECALL     = 32'h00000073;
   localparam logic [31:0] UNIMP     = 32'hc0001073;
   localparam logic [31:0] MRET      = 32'h30200073;
   localparam logic [31:0] SRET      = 32'h10200073;
   localparam logic [31:0] NOP       = 32'h00000013;

   logic        clk, rst;
   logic        csrin_valid, csrin_stall, csrin_csr_write, csrin_is_mret, csrin_is_sret;
   logic [31:0] csrin_inst;
   logic [63:0] csrin_pc, csrin_rs1_data;
   logic [63:0] csrout_rdata, csrout_redirect_pc, csrout_satp;
   logic        csrout_redirect;
   logic [1:0]  csrout_priv;

   csr_trap_unit #(.XLEN(XLEN), .MTVEC_RESET(MTVEC_RST)) dut (
      .clk(clk), .rst(rst),
      .csrin_valid(csrin_valid), .csrin_stall(csrin_stall), .csrin_inst(csrin_inst),
      .csrin_pc(csrin_pc), .csrin_rs1_data(csrin_rs1_data), .csrin_csr_write(csrin_csr_write),
      .csrin_is_mret(csrin_is_mret), .csrin_is_sret(csrin_is_sret),
      .csrout_rdata(csrout_rdata), .csrout_redirect(csrout_redirect),
      .csrout_redirect_pc(csrout_redirect_pc), .csrout_priv(csrout_priv), .csrout_satp(csrout_satp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // ---------------- reference model ----------------
   logic [63:0] m_reg [int];
   logic [1:0]  m_priv;
   logic        m_redir;
   logic [63:0] m_rpc;
   int          impl_addrs [9] = '{'h300, 'h305, 'h341, 'h342, 'h100, 'h105, 'h141, 'h142, 'h180};
   int          test_addrs [10] = '{'h300, 'h305, 'h341, 'h342, 'h100, 'h105, 'h141, 'h142, 'h180, 'h340};
   int          f3_list [6] = '{1, 2, 3, 5, 6, 7};

   function automatic void m_reset();
      m_reg.delete();
      foreach (impl_addrs[i]) if (impl_addrs[i] != 'h100) m_reg[impl_addrs[i]] = 64'h0;
      m_reg['h305] = MTVEC_RST;
      m_priv  = 2'b11;
      m_redir = 1'b0;
      m_rpc   = 64'h0;
   endfunction

   function automatic logic [63:0] m_read(int a);
      if (a == 'h100) return m_reg['h300] & SMASK;
      if (m_reg.exists(a)) return m_reg[a];
      return 64'h0;
   endfunction

   function automatic void m_write(int a, logic [63:0] v);
      case (a)
         'h100: m_reg['h300] = (m_reg['h300] & ~SMASK) | (v & SMASK);
         'h305, 'h105, 'h341, 'h141: m_reg[a] = v & ~64'h3;
         default: if (m_reg.exists(a)) m_reg[a] = v;
      endcase
   endfunction

   function automatic void m_step(logic v, logic st, logic [31:0] ins, logic [63:0] p,
                                  logic [63:0] r, logic cw, logic mr, logic sr);
      logic [63:0] ms, src, old;
      int          f3, z, a;
      bit          taken;
      ms = m_reg['h300];
      taken = 0;
      if (v && !st && !m_redir) begin
         if (cw && (ins == ECALL || ins == UNIMP)) begin
            m_reg['h341] = p;
            m_reg['h342] = (ins == ECALL) ? 64'(8 + int'(m_priv)) : 64'd2;
            ms[12:11] = m_priv;
            ms[7]     = ms[3];
            ms[3]     = 1'b0;
            m_reg['h300] = ms;
            m_rpc  = m_reg['h305];
            m_priv = 2'b11;
            taken  = 1;
         end else if (mr) begin
            m_priv    = ms[12:11];
            ms[3]     = ms[7];
            ms[7]     = 1'b1;
            ms[12:11] = 2'b00;
            m_reg['h300] = ms;
            m_rpc = m_reg['h341];
            taken = 1;
         end else if (sr) begin
            m_priv = {1'b0, ms[8]};
            ms[1]  = ms[5];
            ms[5]  = 1'b1;
            ms[8]  = 1'b0;
            m_reg['h300] = ms;
            m_rpc = m_reg['h141];
            taken = 1;
         end else if (cw) begin
            f3  = int'(ins[14:12]);
            z   = int'(ins[19:15]);
            a   = int'(ins[31:20]);
            src = (f3 >= 5) ? 64'(z) : r;
            old = m_read(a);
            if (f3 == 1 || f3 == 5) m_write(a, src);
            else if ((f3 == 2 || f3 == 6) && z != 0) m_write(a, old | src);
            else if ((f3 == 3 || f3 == 7) && z != 0) m_write(a, old & ~src);
         end
      end
      m_redir = taken;
   endfunction

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [63:0] rdata;
      logic [1:0]  priv;
      logic [63:0] satp;
      logic        redir;
      logic [63:0] rpc;
   } exp_t;
   exp_t sb [$];

   always @(negedge clk) begin : monitor
      exp_t e;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk("rdata", csrout_rdata, e.rdata);
         chk("priv", 64'(csrout_priv), 64'(e.priv));
         chk("satp", csrout_satp, e.satp);
         chk("redirect", 64'(csrout_redirect), 64'(e.redir));
         if (e.redir) chk("redirect_pc", csrout_redirect_pc, e.rpc);
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic v, input logic st, input logic [31:0] ins, input logic [63:0] p,
                        input logic [63:0] r, input logic cw, input logic mr, input logic sr);
      exp_t e;
      @(posedge clk);
      #1;
      csrin_valid = v; csrin_stall = st; csrin_inst = ins; csrin_pc = p;
      csrin_rs1_data = r; csrin_csr_write = cw; csrin_is_mret = mr; csrin_is_sret = sr;
      e.rdata = m_read(int'(ins[31:20]));
      e.priv  = m_priv;
      e.satp  = m_reg['h180];
      e.redir = m_redir;
      e.rpc   = m_rpc;
      sb.push_back(e);
      m_step(v, st, ins, p, r, cw, mr, sr);
   endtask

   function automatic logic [31:0] csr_inst(int a, int rs1f, int f3);
      return {a[11:0], rs1f[4:0], f3[2:0], 5'd1, 7'h73};
   endfunction

   task automatic op(input int a, input int f3, input int rs1f, input logic [63:0] data);
      drive(1'b1, 1'b0, csr_inst(a, rs1f, f3), 64'h4000, data, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic read_chk(input int a, input logic [63:0] exp, input string name);
      op(a, 2, 0, 64'h0);
      #1 chk(name, csrout_rdata, exp);
   endtask

   task automatic nop();
      drive(1'b1, 1'b0, NOP, 64'h4000, 64'h0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic reset_pulse_in_redirect();
      @(posedge clk);
      #1;
      csrin_valid = 1'b0;
      chk("redirect_before_rst", 64'(csrout_redirect), 64'd1);
      rst = 1'b1;
      #1;
      chk("redirect_async_clear", 64'(csrout_redirect), 64'd0);
      chk("redirect_pc_rst", csrout_redirect_pc, 64'h0);
      chk("priv_rst", 64'(csrout_priv), 64'd3);
      m_reset();
      #2 rst = 1'b0;
   endtask

   initial begin
      logic [31:0] ins;
      logic        v, st, cw, mr, sr;
      int          k;
      rst = 1'b1;
      csrin_valid = 0; csrin_stall = 0; csrin_inst = 0; csrin_pc = 0;
      csrin_rs1_data = 0; csrin_csr_write = 0; csrin_is_mret = 0; csrin_is_sret = 0;
      m_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset_priv", 64'(csrout_priv), 64'd3);
      chk("reset_redirect", 64'(csrout_redirect), 64'd0);

      read_chk('h305, MTVEC_RST, "reset_mtvec");
      read_chk('h300, 64'h0, "reset_mstatus");
      op('h305, 1, 2, 64'h80000103);
      op('h300, 2, 3, 64'h8);
      op('h300, 3, 0, 64'hffff);
      read_chk('h305, 64'h80000100, "mtvec_aligned");
      read_chk('h300, 64'h8, "mstatus_rs_rc0");

      // enter S mode through mret with MPP=01
      op('h300, 1, 4, 64'h808);
      op('h341, 1, 4, 64'h500);
      drive(1'b1, 1'b0, MRET, 64'h4000, 64'h0, 1'b0, 1'b1, 1'b0);
      op('h180, 1, 5, 64'hdead);
      #1 chk("priv_s", 64'(csrout_priv), 64'd1);

      drive(1'b1, 1'b0, ECALL, 64'h1000, 64'h0, 1'b1, 1'b0, 1'b0);
      nop();
      #1 chk("ecall_redirect_pc", csrout_redirect_pc, 64'h80000100);
      read_chk('h341, 64'h1000, "ecall_mepc");
      read_chk('h342, 64'd9, "ecall_mcause_s");
      read_chk('h300, 64'h800, "ecall_mstatus");

      op('h300, 3, 6, 64'h1800);
      op('h341, 1, 7, 64'h2004);
      drive(1'b1, 1'b0, MRET, 64'h4000, 64'h0, 1'b0, 1'b1, 1'b0);
      op('h300, 1, 8, 64'hffffffffffffffff);
      #1 chk("mret_redirect_pc", csrout_redirect_pc, 64'h2004);
      chk("mret_priv_u", 64'(csrout_priv), 64'd0);
      read_chk('h300, 64'h80, "mret_mstatus_squash");

      op('h100, 1, 9, 64'hffffffffffffffff);
      read_chk('h300, 64'hC01A2, "sstatus_masked");
      op('h141, 1, 10, 64'h3000);
      drive(1'b1, 1'b0, SRET, 64'h4000, 64'h0, 1'b0, 1'b0, 1'b1);
      nop();
      #1 chk("sret_redirect_pc", csrout_redirect_pc, 64'h3000);
      chk("sret_priv_s", 64'(csrout_priv), 64'd1);

      // randomized traffic
      for (int n = 0; n < 1500; n++) begin
         v  = ($urandom_range(0, 9) != 0);
         st = ($urandom_range(0, 5) == 0);
         cw = 0; mr = 0; sr = 0;
         k  = $urandom_range(0, 19);
         case (k)
            0: begin ins = ECALL; cw = 1; end
            1: begin ins = UNIMP; cw = 1; end
            2: begin ins = MRET; mr = 1; end
            3: begin ins = SRET; sr = 1; end
            4: ins = NOP;
            5: begin
               ins = ($urandom_range(0, 1) == 0) ? ECALL : UNIMP;
               cw = 1'($urandom); mr = 1'($urandom); sr = 1'($urandom);
            end
            default: begin
               ins = csr_inst(test_addrs[$urandom_range(0, 9)],
                              ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 31),
                              f3_list[$urandom_range(0, 5)]);
               cw = 1;
               if ($urandom_range(0, 7) == 0) begin mr = 1'($urandom); sr = 1'($urandom); end
            end
         endcase
         drive(v, st, ins, {$urandom, $urandom} & ~64'h3, {$urandom, $urandom}, cw, mr, sr);
      end
      nop();
      foreach (test_addrs[i]) op(test_addrs[i], 2, 0, 64'h0);

      // stalled unimp, then commit
      drive(1'b1, 1'b1, UNIMP, 64'h7000, 64'h0, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b1, UNIMP, 64'h7000, 64'h0, 1'b1, 1'b0, 1'b0);
      #1 chk("stall_no_redirect", 64'(csrout_redirect), 64'd0);
      drive(1'b1, 1'b0, UNIMP, 64'h7000, 64'h0, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b1, NOP, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, NOP, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0);
      read_chk('h342, 64'd2, "unimp_mcause");
      read_chk('h341, 64'h7000, "unimp_mepc");

      // unimp again with reset landing in the redirect cycle
      drive(1'b1, 1'b0, UNIMP, 64'h7100, 64'h0, 1'b1, 1'b0, 1'b0);
      reset_pulse_in_redirect();
      foreach (test_addrs[i]) op(test_addrs[i], 2, 0, 64'h0);
      nop();

      for (int w = 0; w < 10 && sb.size() != 0; w++) @(posedge clk);
      if (sb.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
